// File: rtl/hilo_unit_if.sv
// Bus between the pipeline and the HI/LO unit: multiply write-back, register moves,
// divide start/operands, and the HI/LO/status outputs.
interface hilo_unit_if #(parameter int DATA_W = 32);
    logic              mult_we;
    logic [DATA_W-1:0] alu_lo;
    logic [DATA_W-1:0] alu_hi;
    logic              mthi_we;
    logic              mtlo_we;
    logic [DATA_W-1:0] wdata;
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_by_zero;

    modport master (
        output mult_we, alu_lo, alu_hi, mthi_we, mtlo_we, wdata,
               div_start, div_signed, dividend, divisor,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  mult_we, alu_lo, alu_hi, mthi_we, mtlo_we, wdata,
               div_start, div_signed, dividend, divisor,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with multiply write-back, MTHI/MTLO moves and a
// 32-step restoring divider (signed or unsigned) that writes quotient/remainder.
module hilo_unit #(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hilo_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t            state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dsr;
    logic              q_neg;
    logic              r_neg;
    logic              zero_div;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              b_zero;
    logic [DATA_W:0]   r_shift;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;

    // Operand magnitudes and one restoring step: shift the next dividend bit in,
    // keep the subtraction only if it did not go negative.
    always_comb begin
        a_mag    = (bus.div_signed && bus.dividend[DATA_W-1]) ? -bus.dividend : bus.dividend;
        b_mag    = (bus.div_signed && bus.divisor[DATA_W-1])  ? -bus.divisor  : bus.divisor;
        b_zero   = (bus.divisor == '0);
        r_shift  = {rem, quo[DATA_W-1]};
        diff     = r_shift - {1'b0, dsr};
        step_rem = rem;
        step_quo = quo;
        if (!diff[DATA_W]) begin
            step_rem = diff[DATA_W-1:0];
            step_quo = {quo[DATA_W-2:0], 1'b1};
        end else begin
            step_rem = r_shift[DATA_W-1:0];
            step_quo = {quo[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
            count    <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_start) begin
                        // A zero divisor preloads the final answer so FIX writes it unchanged.
                        quo      <= b_zero ? '1 : a_mag;
                        rem      <= b_zero ? a_mag : '0;
                        dsr      <= b_mag;
                        q_neg    <= bus.div_signed && !b_zero &&
                                    (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
                        r_neg    <= bus.div_signed && bus.dividend[DATA_W-1];
                        zero_div <= b_zero;
                        count    <= '0;
                        busy_q   <= 1'b1;
                        state    <= b_zero ? FIX : DIV;
                    end else if (bus.mult_we) begin
                        hi_q <= bus.alu_hi;
                        lo_q <= bus.alu_lo;
                    end else begin
                        if (bus.mthi_we) hi_q <= bus.wdata;
                        if (bus.mtlo_we) lo_q <= bus.wdata;
                    end
                end
                DIV: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    lo_q   <= q_neg ? -quo : quo;
                    hi_q   <= r_neg ? -rem : rem;
                    done_q <= 1'b1;
                    dbz_q  <= zero_div;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width of HI, LO and all operands; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mult_we  input  1  write ALU multiply result into HI/LO.
REQ-005 alu_lo  input  32  low product word from the ALU (r).
REQ-006 alu_hi  input  32  high product word from the ALU (r2).
REQ-007 mthi_we  input  1  write wdata into HI.
REQ-008 mtlo_we  input  1  write wdata into LO.
REQ-009 wdata  input  32  register-move data.
REQ-010 div_start  input  1  start a division; sampled only in IDLE.
REQ-011 div_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
REQ-012 dividend  input  32  numerator; sampled with div_start.
REQ-013 divisor  input  32  denominator; sampled with div_start.
REQ-014 hi  output  32  HI register.
REQ-015 lo  output  32  LO register.
REQ-016 busy  output  1  division in progress.
REQ-017 done  output  1  one-cycle pulse; division result has been written.
REQ-018 div_by_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0.

Function
REQ-019 The block SHALL implement FSM states IDLE, DIV and FIX.
REQ-020 IDLE, edge T0 with div_start=1: the block SHALL capture the operand magnitudes (two's-complement absolute value if div_signed, else raw), the quotient sign (sign XOR) and the remainder sign (dividend sign), clear the iteration counter, set busy=1, and go to DIV.
REQ-021 In DIV, each edge SHALL perform one restoring shift-subtract step on a 33-bit partial remainder. The counter SHALL increment 0..31, and the block SHALL go to FIX on the edge that completes step 32 (T32).
REQ-022 At edge T33 (FIX), the block SHALL write LO=quotient and HI=remainder, each negated if its sign flag is set. It SHALL set done=1, clear busy to 0, and return to IDLE. Total latency from start to done is 34 edges.
REQ-023 done and div_by_zero SHALL be high for exactly one cycle and then clear on the next edge.
REQ-024 When divisor=0 at T0, the block SHALL skip DIV, go to FIX, and at T1 write HI=dividend and LO=0xFFFFFFFF. It SHALL assert done=1 and div_by_zero=1; busy is high for one cycle.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wraps, no trap).
REQ-026 In IDLE without div_start: mult_we=1 SHALL load HI=alu_hi, LO=alu_lo. Otherwise mthi_we SHALL load HI=wdata and mtlo_we SHALL load LO=wdata; both may act in the same cycle.
REQ-027 Same-edge priority SHALL be div_start > mult_we > mthi_we/mtlo_we. Lower-priority writes on that edge SHALL be discarded.
REQ-028 While busy=1, div_start, mult_we, mthi_we and mtlo_we SHALL be ignored, and hi/lo SHALL hold their pre-division values until T33.
REQ-029 hi and lo SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-030 rst_n=0 SHALL, asynchronously and at any state including mid-division, force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, and clear the counter. Any in-flight division is discarded.
REQ-031 After rst_n rises, the first edge with div_start=1 SHALL start a fresh division.

Verification
REQ-032 DIVU 100/7: start at T0 -> busy=1 for T1..T33; at T33 lo=14, hi=2, done=1 for one cycle, div_by_zero=0.
REQ-033 DIV -7/2 signed -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 5/0 -> at T1 hi=5, lo=0xFFFFFFFF, done=1, div_by_zero=1.
REQ-035 IDLE mult_we=1 with alu_hi=0x1, alu_lo=0xFFFFFFFE -> hi=0x1, lo=0xFFFFFFFE. Same edge with div_start=1 -> mult write discarded and division starts.
REQ-036 Division in flight, mthi_we=1 wdata=0xAA at T10 -> ignored; hi unchanged until T33 result.
REQ-037 rst_n low at T15 of a division -> immediately busy=0, hi=lo=0, no done pulse. A new start after release completes with correct 34-edge latency.
